// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared processor constants for the fetch stage
package ifetch_queue_pkg;
  localparam int IMEM_ADDR_W = 12;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] NOP = 32'b0;
  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB = 22;
  localparam int RS_LSB = 17;
  localparam int RT_LSB = 12;
endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: imem, redirect and decode-handshake signals of the fetch stage
interface ifetch_queue_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH = 4
);
  logic [ADDR_W-1:0] address_imem;
  logic [31:0] q_imem;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus_one;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  modport master (
    output address_imem, out_valid, out_instr, out_pc, out_pc_plus_one, occupancy,
    input q_imem, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input address_imem, out_valid, out_instr, out_pc, out_pc_plus_one, occupancy,
    output q_imem, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// fetch_fifo: circular buffer of PC-tagged instructions with flush
module fetch_fifo #(
  parameter int W = 44,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic wr;
  assign wr = push & ~flush;
  // next pointers, count and storage; flush wins over push/pop
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[tail_q] = din;
    head_d = flush ? '0 : head_q + PW'(pop);
    tail_d = flush ? '0 : tail_q + PW'(wr);
    count_d = flush ? '0 : count_q + CW'(wr) - CW'(pop);
  end
  // storage carries no reset; occupancy decides what is visible
  always_ff @(posedge clock) mem_q <= mem_d;
  // pointer and count registers
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  assign dout = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner driving imem and a PC-tagged instruction queue to decode
module ifetch_queue import ifetch_queue_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clock,
  input logic reset,
  ifetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d;
  logic valid, pop, push, issue;
  logic [CW-1:0] count;
  logic [ADDR_W+31:0] head;
  assign valid = count != '0;
  assign pop = valid & bus.out_ready & ~bus.redirect_valid;
  assign push = inflight_q & ~bus.redirect_valid;
  assign issue = ({1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop)) < (CW+1)'(DEPTH);
  // redirect restarts fetch at its target; otherwise fetch only while credit remains
  always_comb begin
    inflight_d = bus.redirect_valid | issue;
    inflight_pc_d = bus.redirect_valid ? bus.redirect_pc : issue ? fetch_pc_q : inflight_pc_q;
    fetch_pc_d = bus.redirect_valid ? bus.redirect_pc + ADDR_W'(1) :
                 issue ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
  end
  // fetch PC and in-flight request tracking
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  fetch_fifo #(.W(ADDR_W+32), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(bus.redirect_valid),
    .push(push),
    .pop(pop),
    .din({inflight_pc_q, bus.q_imem}),
    .dout(head),
    .count(count)
  );
  assign bus.address_imem = !reset ? RESET_PC : bus.redirect_valid ? bus.redirect_pc : fetch_pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? head[31:0] : NOP;
  assign bus.out_pc = valid ? head[ADDR_W+31:32] : '0;
  assign bus.out_pc_plus_one = valid ? head[ADDR_W+31:32] + ADDR_W'(1) : '0;
  assign bus.occupancy = count;
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios for the fetch queue against a registered imem model
module tb_ifetch_queue;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  ifetch_queue_if #(.ADDR_W(12), .DEPTH(4)) bus ();
  ifetch_queue #(.ADDR_W(12), .DEPTH(4), .RESET_PC(12'h000)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) bus.q_imem <= 32'hA000_0000 | {20'h0, bus.address_imem};
  logic [56:0] obs;
  assign obs = {bus.out_valid, bus.out_pc, bus.out_instr, bus.out_pc_plus_one};

  function automatic logic [56:0] hv(input logic [11:0] pc, input logic [11:0] ppo);
    return {1'b1, pc, 32'hA000_0000 | {20'h0, pc}, ppo};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    reset = 1'b0;
    step(2);
    checks++;
    if (obs !== 57'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 57'h0);
    end
    checks++;
    if ({bus.occupancy, bus.address_imem} !== {3'd0, 12'h000}) begin
      failures++;
      $display("FAIL reset_occ_addr got=%h exp=%h", {bus.occupancy, bus.address_imem}, 15'h0);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if ({bus.out_valid, bus.address_imem} !== {1'b0, 12'h001}) begin
      failures++;
      $display("FAIL edge1_state got=%h exp=%h", {bus.out_valid, bus.address_imem}, {1'b0, 12'h001});
    end
    step(1);
  endtask

  task automatic test_stream();
    logic [11:0] pcs [8] = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007};
    logic [11:0] ppos [8] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs !== hv(pcs[i], ppos[i])) begin
        failures++;
        $display("FAIL stream_%0d got=%h exp=%h", i, obs, hv(pcs[i], ppos[i]));
      end
      step(1);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    apply_reset();
    step(12);
    checks++;
    if ({bus.occupancy, bus.address_imem} !== {3'd4, 12'h004}) begin
      failures++;
      $display("FAIL full_occ_addr got=%h exp=%h", {bus.occupancy, bus.address_imem}, {3'd4, 12'h004});
    end
    step(10);
    checks++;
    if ({bus.occupancy, bus.address_imem} !== {3'd4, 12'h004}) begin
      failures++;
      $display("FAIL full_hold got=%h exp=%h", {bus.occupancy, bus.address_imem}, {3'd4, 12'h004});
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs !== hv(12'(i), 12'(i + 1))) begin
        failures++;
        $display("FAIL drain_%0d got=%h exp=%h", i, obs, hv(12'(i), 12'(i + 1)));
      end
      step(1);
    end
  endtask

  task automatic test_redirect_flush();
    bus.out_ready = 1'b0;
    apply_reset();
    step(4);
    checks++;
    if (bus.occupancy !== 3'd3) begin
      failures++;
      $display("FAIL pre_redirect_occ got=%0d exp=%0d", bus.occupancy, 3);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h100;
    #1;
    checks++;
    if (bus.address_imem !== 12'h100) begin
      failures++;
      $display("FAIL redirect_addr got=%h exp=%h", bus.address_imem, 12'h100);
    end
    step(1);
    bus.redirect_valid = 1'b0;
    checks++;
    if ({obs, bus.occupancy} !== {57'h0, 3'd0}) begin
      failures++;
      $display("FAIL flush_empty got=%h exp=%h", {obs, bus.occupancy}, 60'h0);
    end
    bus.out_ready = 1'b1;
    step(1);
    checks++;
    if (obs !== hv(12'h100, 12'h101)) begin
      failures++;
      $display("FAIL target_head got=%h exp=%h", obs, hv(12'h100, 12'h101));
    end
    step(1);
    checks++;
    if (obs !== hv(12'h101, 12'h102)) begin
      failures++;
      $display("FAIL target_next got=%h exp=%h", obs, hv(12'h101, 12'h102));
    end
    step(1);
    checks++;
    if (obs !== hv(12'h102, 12'h103)) begin
      failures++;
      $display("FAIL target_third got=%h exp=%h", obs, hv(12'h102, 12'h103));
    end
  endtask

  task automatic test_wrap();
    logic [11:0] pcs [3] = '{12'hFFE, 12'hFFF, 12'h000};
    logic [11:0] ppos [3] = '{12'hFFF, 12'h000, 12'h001};
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'hFFE;
    step(1);
    bus.redirect_valid = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== hv(pcs[i], ppos[i])) begin
        failures++;
        $display("FAIL wrap_%0d got=%h exp=%h", i, obs, hv(pcs[i], ppos[i]));
      end
      step(1);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h020;
    step(1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_valid got=%b exp=%b", bus.out_valid, 1'b0);
    end
    bus.redirect_pc = 12'h040;
    step(1);
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_valid got=%b exp=%b", bus.out_valid, 1'b0);
    end
    step(1);
    checks++;
    if (obs !== hv(12'h040, 12'h041)) begin
      failures++;
      $display("FAIL b2b_head got=%h exp=%h", obs, hv(12'h040, 12'h041));
    end
    step(1);
    checks++;
    if (obs !== hv(12'h041, 12'h042)) begin
      failures++;
      $display("FAIL b2b_next got=%h exp=%h", obs, hv(12'h041, 12'h042));
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    step(8);
    checks++;
    if (bus.occupancy !== 3'd4) begin
      failures++;
      $display("FAIL mid_full got=%0d exp=%0d", bus.occupancy, 4);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({obs, bus.occupancy, bus.address_imem} !== 72'h0) begin
      failures++;
      $display("FAIL mid_reset_now got=%h exp=%h", {obs, bus.occupancy, bus.address_imem}, 72'h0);
    end
    step(1);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step(1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_edge1 got=%b exp=%b", bus.out_valid, 1'b0);
    end
    step(1);
    checks++;
    if (obs !== hv(12'h000, 12'h001)) begin
      failures++;
      $display("FAIL mid_edge2 got=%h exp=%h", obs, hv(12'h000, 12'h001));
    end
    step(1);
    checks++;
    if (obs !== hv(12'h001, 12'h002)) begin
      failures++;
      $display("FAIL mid_edge3 got=%h exp=%h", obs, hv(12'h001, 12'h002));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
